// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the select of a downstream 16:1 mux, waits a
// fixed settle time, captures the mux output and hands each sample to a
// consumer over valid/ready. Supports a single-channel read or an ascending
// scan over a latched 16-bit channel enable mask; completion is a one-cycle
// done pulse.
module mux_scan_sequencer #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [3:0]       chan_in,
    input  logic [15:0]      enable_mask,
    output logic [3:0]       sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [WIDTH-1:0] smp_data,
    output logic [3:0]       smp_chan,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OUTPUT
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic             smp_valid_q, smp_valid_d;
    logic [WIDTH-1:0] smp_data_q, smp_data_d;
    logic [3:0]       smp_chan_q, smp_chan_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic [15:0]      mask_q, mask_d;

    logic [3:0]       first_chan;
    logic [3:0]       first_idx;
    logic [3:0]       next_chan;
    logic [3:0]       next_idx;
    logic             has_next;

    // Lowest set bit of the incoming mask (scan start channel).
    // Walks from bit 15 down so the last hit, i.e. the lowest index, wins.
    always_comb begin
        first_chan = '0;
        first_idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            first_idx = 4'(15 - i);
            if (enable_mask[first_idx]) begin
                first_chan = first_idx;
            end
        end
    end

    // Next higher set bit of the latched mask strictly above the current select.
    always_comb begin
        has_next  = 1'b0;
        next_chan = '0;
        next_idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            next_idx = 4'(15 - i);
            if (mask_q[next_idx] && (next_idx > sel_q)) begin
                has_next  = 1'b1;
                next_chan = next_idx;
            end
        end
    end

    // Next-state and output logic for the IDLE/SETTLE/OUTPUT sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        smp_valid_d = smp_valid_q;
        smp_data_d  = smp_data_q;
        smp_chan_d  = smp_chan_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mode_d      = mode_q;
        mask_d      = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    mask_d = enable_mask;
                    if (mode && (enable_mask == '0)) begin
                        // Empty scan completes immediately without going busy.
                        done_d = 1'b1;
                    end else begin
                        sel_d   = mode ? first_chan : chan_in;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    smp_data_d  = mux_out;
                    smp_chan_d  = sel_q;
                    smp_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (smp_valid_q && smp_ready) begin
                    smp_valid_d = 1'b0;
                    if (!mode_q || !has_next) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        sel_d   = next_chan;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            smp_chan_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            smp_valid_q <= smp_valid_d;
            smp_data_q  <= smp_data_d;
            smp_chan_q  <= smp_chan_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
        end
    end

    assign sel       = sel_q;
    assign smp_valid = smp_valid_q;
    assign smp_data  = smp_data_q;
    assign smp_chan  = smp_chan_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed testbench for mux_scan_sequencer (WIDTH=8, SETTLE=2). The mux
// model returns {data_hi, sel} so both the channel index and the upper data
// bits of each capture can be checked.
module tb_mux_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [3:0]  chan_in;
    logic [15:0] enable_mask;
    logic [3:0]  sel;
    logic [7:0]  mux_out;
    logic        smp_valid;
    logic        smp_ready;
    logic [7:0]  smp_data;
    logic [3:0]  smp_chan;
    logic        busy;
    logic        done;
    logic [3:0]  data_hi;

    int n_cmp;
    int n_err;

    mux_scan_sequencer #(
        .WIDTH (8),
        .SETTLE(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .chan_in    (chan_in),
        .enable_mask(enable_mask),
        .sel        (sel),
        .mux_out    (mux_out),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_data   (smp_data),
        .smp_chan   (smp_chan),
        .busy       (busy),
        .done       (done)
    );

    assign mux_out = {data_hi, sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m, input logic [3:0] ch, input logic [15:0] mask);
        mode        = m;
        chan_in     = ch;
        enable_mask = mask;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    int          scan_ch [4];
    logic [3:0]  got_ch [$];
    int          n_done;

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        chan_in     = '0;
        enable_mask = '0;
        smp_ready   = 1'b1;
        data_hi     = 4'h0;
        scan_ch     = '{0, 5, 10, 15};

        // ---- reset state ----
        tick();
        tick();
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_valid", 32'(smp_valid), 32'd0);
        check("rst_data",  32'(smp_data),  32'd0);
        check("rst_chan",  32'(smp_chan),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        rst = 1'b0;
        tick();

        // ---- single read, channel 5 ----
        start_op(1'b0, 4'd5, 16'h0000);                    // after edge t+1
        check("single_sel_t1",   32'(sel),       32'd5);
        check("single_busy_t1",  32'(busy),      32'd1);
        check("single_valid_t1", 32'(smp_valid), 32'd0);
        tick();                                            // t+2
        check("single_valid_t2", 32'(smp_valid), 32'd0);
        tick();                                            // t+3
        check("single_valid_t3", 32'(smp_valid), 32'd1);
        check("single_chan_t3",  32'(smp_chan),  32'd5);
        check("single_data_t3",  32'(smp_data),  32'h05);
        tick();                                            // t+4
        check("single_done_t4",  32'(done),      32'd1);
        check("single_busy_t4",  32'(busy),      32'd0);
        check("single_valid_t4", 32'(smp_valid), 32'd0);
        tick();
        check("single_done_t5",  32'(done),      32'd0);

        // ---- scan 8421 with ready held high ----
        data_hi = 4'hC;
        start_op(1'b1, 4'd0, 16'h8421);
        check("scan_sel_t1",  32'(sel),  32'd0);
        check("scan_busy_t1", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("scan_gap_%0d", k),   32'(smp_valid), 32'd0);
            check($sformatf("scan_sel_%0d", k),   32'(sel),       32'(scan_ch[k]));
            tick();
            check($sformatf("scan_valid_%0d", k), 32'(smp_valid), 32'd1);
            check($sformatf("scan_chan_%0d", k),  32'(smp_chan),  32'(scan_ch[k]));
            check($sformatf("scan_data_%0d", k),  32'(smp_data),  32'hC0 | 32'(scan_ch[k]));
            check($sformatf("scan_nodone_%0d", k), 32'(done),     32'd0);
            tick();
        end
        check("scan_done",  32'(done),      32'd1);
        check("scan_busy",  32'(busy),      32'd0);
        check("scan_valid", 32'(smp_valid), 32'd0);
        tick();
        check("scan_done_end", 32'(done), 32'd0);

        // ---- backpressure on channel 5 ----
        data_hi = 4'h3;
        start_op(1'b1, 4'd0, 16'h8421);
        tick();
        tick();
        check("bp_ch0_valid", 32'(smp_valid), 32'd1);
        tick();                                            // channel 0 accepted
        smp_ready = 1'b0;
        check("bp_sel5", 32'(sel), 32'd5);
        tick();
        tick();
        check("bp_valid_rise", 32'(smp_valid), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("bp_hold_valid_%0d", c), 32'(smp_valid), 32'd1);
            check($sformatf("bp_hold_chan_%0d", c),  32'(smp_chan),  32'd5);
            check($sformatf("bp_hold_data_%0d", c),  32'(smp_data),  32'h35);
            check($sformatf("bp_hold_sel_%0d", c),   32'(sel),       32'd5);
        end
        smp_ready = 1'b1;
        #2;
        check("bp_sel_before_edge", 32'(sel), 32'd5);
        tick();
        check("bp_sel_after_edge",  32'(sel),       32'd10);
        check("bp_valid_after",     32'(smp_valid), 32'd0);
        wait_done("bp_done", 20);
        tick();

        // ---- empty mask ----
        start_op(1'b1, 4'd0, 16'h0000);
        check("empty_done_t1",  32'(done),      32'd1);
        check("empty_busy_t1",  32'(busy),      32'd0);
        check("empty_valid_t1", 32'(smp_valid), 32'd0);
        tick();
        check("empty_done_t2",  32'(done),      32'd0);
        check("empty_busy_t2",  32'(busy),      32'd0);
        check("empty_valid_t2", 32'(smp_valid), 32'd0);

        // ---- ignored start / mask change mid-scan ----
        data_hi = 4'h0;
        mode        = 1'b1;
        enable_mask = 16'h0003;
        start       = 1'b1;
        tick();                                            // accepted
        enable_mask = 16'hFFFF;
        tick();                                            // start held while busy
        start = 1'b0;
        n_done = 0;
        got_ch.delete();
        for (int c = 0; c < 30; c++) begin
            if (smp_valid) got_ch.push_back(smp_chan);
            if (done) n_done++;
            tick();
        end
        check("ign_count", 32'(got_ch.size()), 32'd2);
        if (got_ch.size() >= 2) begin
            check("ign_first",  32'(got_ch[0]), 32'd0);
            check("ign_second", 32'(got_ch[1]), 32'd1);
        end
        check("ign_done_count", 32'(n_done), 32'd1);

        // ---- asynchronous reset mid-scan ----
        smp_ready = 1'b0;
        start_op(1'b1, 4'd0, 16'h0080);
        tick();
        tick();
        check("ar_valid_pre", 32'(smp_valid), 32'd1);
        check("ar_sel_pre",   32'(sel),       32'd7);
        #2 rst = 1'b1;                                      // between clock edges
        #1;
        check("ar_sel",   32'(sel),       32'd0);
        check("ar_valid", 32'(smp_valid), 32'd0);
        check("ar_data",  32'(smp_data),  32'd0);
        check("ar_chan",  32'(smp_chan),  32'd0);
        check("ar_busy",  32'(busy),      32'd0);
        check("ar_done",  32'(done),      32'd0);
        tick();
        rst       = 1'b0;
        smp_ready = 1'b1;
        n_done    = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) n_done++;
        end
        check("ar_no_done", 32'(n_done), 32'd0);
        start_op(1'b0, 4'd3, 16'h0000);
        check("ar_restart_sel",  32'(sel),  32'd3);
        check("ar_restart_busy", 32'(busy), 32'd1);
        wait_done("ar_restart_done", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
